hazard_forward_ctrl: RTL
========================

# hazard_forward_ctrl

Forwarding and load-use controller for the pipelined datapath's operand-B and operand-A muxes. It tracks the destination register of the instructions in the EX and WB stages. Against those it compares the source addresses of the instruction in decode and drives the EX/WB hazard selects that steer each operand mux between register-file data, the EX forward path and BUS_D. It also detects load-use conflicts, requests a one-cycle decode stall with bubble insertion, and honours branch flushes.

## Interface
- REG_AW, 5, register address width (R0 hardwired zero)
- CNT_W, 16, width of saturating stall counter
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decode-stage instruction valid
- AA, BA  in  REG_AW  decode source A/B register addresses
- MA, MB  in  1  decode operand select (1 = constant/PC, no register read)
- DA  in  REG_AW  decode destination address
- RW  in  1  decode register-write enable
- MD_load  in  1  decode instruction is a memory load
- flush  in  1  branch taken: kill decode instruction
- EX_Hazard_A, EX_Hazard_B  out  1  forward from EX path
- WB_Hazard_A, WB_Hazard_B  out  1  forward from BUS_D
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Internal stage records ex_{DA,RW,load} and wb_{DA,RW}. A record with RW=0 is a bubble.
- Match rule, shown for operand B (A is identical with AA/MA): EX match = dec_valid & !MB & ex_RW & (BA==ex_DA) & (BA!=0). WB match uses wb_RW and wb_DA in the same way.
- Load-use condition: an EX match on either operand while ex_load=1.
- stall = load-use & !flush & dec_valid.
- Hazard outputs:
  - EX_Hazard_x = EX match & !stall.
  - WB_Hazard_x = WB match & !stall.
  - EX and WB may both be 1. The mux gives EX priority.
- All four hazard outputs are forced to 0 while stall=1. The decode instruction is re-evaluated the following cycle.
- Stage advance on each clk edge when reset=0:
  - wb <= ex.
  - ex <= bubble if (stall | flush | !dec_valid), else {DA, RW, MD_load}.
- A DA of 0 with RW=1 is stored as-is but can never match because of the BA!=0 / AA!=0 check.
- FSM:
  - RUN → STALL when stall=1.
  - STALL → RUN unconditionally, since the load has moved to WB and no longer causes an EX match.
  - A second consecutive stall is impossible by construction. The bench flags it as an assertion failure.
- stall_cnt increments on every edge where stall=1. It saturates at 2^CNT_W−1.

## Timing
- The hazard and stall outputs are combinational from the decode inputs and the registered stage records, with zero-cycle latency. They are valid in the same cycle the decode fields are presented.
- Stage records update one cycle after capture. An instruction decoded in cycle n:
  - is compared as EX in cycle n+1;
  - is compared as WB in cycle n+2;
  - is invisible in cycle n+3, when the register file holds the value.
- Reset (synchronous, reset=1 at an edge):
  - ex and wb records clear to bubble (RW=0, DA=0, load=0).
  - FSM goes to RUN and stall_cnt to 0.
  - While reset is held, all outputs evaluate to 0 because both records are bubbles.
- Reset asserted mid-stall: FSM returns to RUN and the records clear. The following cycle shows stall=0.
- flush and a load-use condition in the same cycle: flush wins. stall=0, a bubble goes into EX, and stall_cnt is unchanged.
- dec_valid=0: all hazard outputs and stall are 0, and a bubble enters EX.

## Structure
- Shared package hazard_pkg:
  - REG_AW;
  - stage record typedef {DA, RW, load};
  - FSM state enum {RUN, STALL};
  - BUBBLE constant.
- One sub-module, hazard_cmp: a pure combinational comparator for one operand. Inputs are the source address, the select bit, and the EX/WB records. Outputs are ex_match, wb_match and load_hit. It is instantiated twice, for A and B.
- The top level holds the stage registers, the FSM, the stall counter and the output gating.

## Test plan
- ADD R3 then SUB R5,R3 back-to-back → cycle 2: EX_Hazard_B=1, WB_Hazard_B=0. With the SUB delayed one cycle: WB_Hazard_B=1 only.
- R3 written in EX and WB, BA=3 → EX_Hazard_B=1 and WB_Hazard_B=1. With MB=1 → both 0.
- LD R4 then ADD R6,R4 → stall=1 for exactly one cycle with all hazards 0. Next cycle: WB_Hazard=1, stall=0, stall_cnt=1.
- Write to R0, then BA=0 → no hazard asserted.
- Load-use condition with flush=1 in the same cycle → stall=0, EX record becomes a bubble, stall_cnt unchanged.
- reset asserted during STALL → next cycle stall=0, all hazards 0, stall_cnt=0. Then force stall_cnt to 2^CNT_W−1 and trigger a stall → the counter stays saturated.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / load-use controller: stage record,
// FSM state encoding and the bubble constant.
package hazard_pkg;

   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] da;
      logic              rw;
      logic              load;
   } stage_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fsm_t;

   localparam stage_t BUBBLE = '{da: '0, rw: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_cmp.sv
// Per-operand comparator: matches a decode source address against the
// EX and WB stage records and flags a load still sitting in EX.
module hazard_cmp
   import hazard_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic              sel,
   input  stage_t            ex_rec,
   input  stage_t            wb_rec,
   output logic              ex_match,
   output logic              wb_match,
   output logic              load_hit
);

   logic src_live;

   // R0 reads and constant/PC operands never depend on an in-flight write.
   assign src_live = !sel && (src != '0);
   assign ex_match = src_live && ex_rec.rw && (src == ex_rec.da);
   assign wb_match = src_live && wb_rec.rw && (src == wb_rec.da);
   assign load_hit = ex_match && ex_rec.load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select and load-use stall controller: holds the EX/WB
// destination records, gates the operand-mux hazard selects and counts stalls.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = hazard_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] AA,
   input  logic [REG_AW-1:0] BA,
   input  logic              MA,
   input  logic              MB,
   input  logic [REG_AW-1:0] DA,
   input  logic              RW,
   input  logic              MD_load,
   input  logic              flush,
   output logic              EX_Hazard_A,
   output logic              EX_Hazard_B,
   output logic              WB_Hazard_A,
   output logic              WB_Hazard_B,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   stage_t            ex_rec_p1;
   stage_t            wb_rec_p2;
   fsm_t              state_q;
   fsm_t              state_d;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic a_ex_match, a_wb_match, a_load_hit;
   logic b_ex_match, b_wb_match, b_load_hit;
   logic load_use;
   logic kill_p0;

   hazard_cmp u_cmp_a (
      .src      (AA),
      .sel      (MA),
      .ex_rec   (ex_rec_p1),
      .wb_rec   (wb_rec_p2),
      .ex_match (a_ex_match),
      .wb_match (a_wb_match),
      .load_hit (a_load_hit)
   );

   hazard_cmp u_cmp_b (
      .src      (BA),
      .sel      (MB),
      .ex_rec   (ex_rec_p1),
      .wb_rec   (wb_rec_p2),
      .ex_match (b_ex_match),
      .wb_match (b_wb_match),
      .load_hit (b_load_hit)
   );

   // Decode stage (p0): combinational hazard and stall evaluation.
   assign load_use    = dec_valid && (a_load_hit || b_load_hit);
   assign stall       = load_use && !flush;
   assign EX_Hazard_A = dec_valid && a_ex_match && !stall;
   assign EX_Hazard_B = dec_valid && b_ex_match && !stall;
   assign WB_Hazard_A = dec_valid && a_wb_match && !stall;
   assign WB_Hazard_B = dec_valid && b_wb_match && !stall;
   assign kill_p0     = stall || flush || !dec_valid;
   assign stall_cnt   = stall_cnt_q;

   // EX (p1) and WB (p2) stage records.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rec_p1 <= BUBBLE;
         wb_rec_p2 <= BUBBLE;
      end else begin
         wb_rec_p2 <= ex_rec_p1;
         if (kill_p0)
            ex_rec_p1 <= BUBBLE;
         else
            ex_rec_p1 <= '{da: DA, rw: RW, load: MD_load};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (stall)
            stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   // The stalled load has advanced to WB by the next cycle, so STALL always
   // falls back to RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall) state_d = STALL;
         STALL:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

endmodule
